// File: rtl/mesi_bus_arbiter_if.sv
// Snoop-bus signal bundle shared by the MESI bus arbiter and its N cache controllers.
// The arbiter side uses the master modport; the cache side uses slave.
interface mesi_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req_rd;
    logic [N-1:0] req_wr;
    logic [N-1:0] snoop_hit;
    logic [N-1:0] grant;
    logic [N-1:0] BR;
    logic [N-1:0] BW;
    logic [N-1:0] S;
    logic [N-1:0] done;
    logic         busy;

    modport master (
        input  req_rd, req_wr, snoop_hit,
        output grant, BR, BW, S, done, busy
    );

    modport slave (
        output req_rd, req_wr, snoop_hit,
        input  grant, BR, BW, S, done, busy
    );
endinterface

// File: rtl/mesi_bus_arbiter.sv
// Round-robin snoop-bus arbiter for MESI caches: IDLE -> BCAST -> SNOOP x SNOOP_LAT -> RESP.
// Every bus output is a register, loaded on the edge that enters the state it belongs to.
module mesi_bus_arbiter #(
    parameter int N         = 4,
    parameter int SNOOP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mesi_bus_arbiter_if.master    bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SNOOP_LAT + 1);

    typedef enum logic [1:0] {IDLE, BCAST, SNOOP, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          op_wr;
    logic          hit;
    logic          mask_last;
    logic [CW-1:0] cnt;

    logic [N-1:0]  win_oh;
    logic [N-1:0]  pick_oh;
    logic [N-1:0]  elig;
    logic [IW-1:0] pick;
    logic          found;
    logic          hit_nxt;
    logic [IW-1:0] ptr_nxt;

    assign win_oh  = N'(1) << winner;
    assign pick_oh = N'(1) << pick;
    // The just-finished winner sits out one IDLE cycle so a late-dropped request is not re-served.
    assign elig    = (bus.req_rd | bus.req_wr) & ~(mask_last ? win_oh : '0);
    assign hit_nxt = hit | (|(bus.snoop_hit & ~win_oh));
    assign ptr_nxt = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;

    always_comb begin : rr_search
        int j;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            op_wr     <= 1'b0;
            hit       <= 1'b0;
            mask_last <= 1'b0;
            cnt       <= '0;
            bus.grant <= '0;
            bus.BR    <= '0;
            bus.BW    <= '0;
            bus.S     <= '0;
            bus.done  <= '0;
            bus.busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (found) begin
                        winner    <= pick;
                        op_wr     <= bus.req_wr[pick];
                        state     <= BCAST;
                        bus.grant <= pick_oh;
                        bus.BR    <= bus.req_wr[pick] ? '0 : ~pick_oh;
                        bus.BW    <= bus.req_wr[pick] ? ~pick_oh : '0;
                        bus.busy  <= 1'b1;
                    end
                end
                BCAST: begin
                    bus.BR <= '0;
                    bus.BW <= '0;
                    cnt    <= '0;
                    state  <= SNOOP;
                end
                SNOOP: begin
                    hit <= hit_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SNOOP_LAT - 1)) begin
                        state    <= RESP;
                        bus.done <= win_oh;
                        bus.S    <= (!op_wr && hit_nxt) ? win_oh : '0;
                    end
                end
                RESP: begin
                    bus.done  <= '0;
                    bus.S     <= '0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    hit       <= 1'b0;
                    ptr       <= ptr_nxt;
                    mask_last <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter: one instance at SNOOP_LAT=1, one at SNOOP_LAT=3.
module tb_mesi_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;

    mesi_bus_arbiter_if #(.N(4)) bif ();
    mesi_bus_arbiter_if #(.N(4)) bif3 ();

    mesi_bus_arbiter #(.N(4), .SNOOP_LAT(1)) dut  (.clk(clk), .reset(reset), .bus(bif.master));
    mesi_bus_arbiter #(.N(4), .SNOOP_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bif3.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bif.req_rd  = '0; bif.req_wr  = '0; bif.snoop_hit  = '0;
        bif3.req_rd = '0; bif3.req_wr = '0; bif3.snoop_hit = '0;
        #2;
        chk("rst_grant", 8'(bif.grant), 8'h0);
        chk("rst_busy",  8'(bif.busy),  8'h0);
        chk("rst_done",  8'(bif.done),  8'h0);
        tick(2);
        reset = 1'b1;
        tick();

        // single read, a third-party cache hits
        bif.req_rd = 4'b0001;
        tick();
        chk("t1_grant_bcast", 8'(bif.grant), 8'b0001);
        chk("t1_br",          8'(bif.BR),    8'b1110);
        chk("t1_bw",          8'(bif.BW),    8'b0000);
        chk("t1_busy",        8'(bif.busy),  8'h1);
        tick();
        chk("t1_grant_snoop", 8'(bif.grant), 8'b0001);
        chk("t1_br_snoop",    8'(bif.BR),    8'b0000);
        bif.snoop_hit = 4'b0100;
        tick();
        chk("t1_done",        8'(bif.done),  8'b0001);
        chk("t1_s",           8'(bif.S),     8'b0001);
        chk("t1_grant_resp",  8'(bif.grant), 8'b0001);
        bif.req_rd = '0; bif.snoop_hit = '0;
        tick();
        chk("t1_grant_idle",  8'(bif.grant), 8'b0000);
        chk("t1_done_idle",   8'(bif.done),  8'b0000);
        chk("t1_busy_idle",   8'(bif.busy),  8'h0);
        tick();

        // write with hits: S must stay low
        bif.req_wr = 4'b0010;
        tick();
        chk("t2_bw",    8'(bif.BW),    8'b1101);
        chk("t2_br",    8'(bif.BR),    8'b0000);
        chk("t2_grant", 8'(bif.grant), 8'b0010);
        bif.snoop_hit = 4'b1101;
        tick();
        chk("t2_br_snoop", 8'(bif.BR), 8'b0000);
        chk("t2_bw_snoop", 8'(bif.BW), 8'b0000);
        tick();
        chk("t2_done", 8'(bif.done), 8'b0010);
        chk("t2_s",    8'(bif.S),    8'b0000);
        chk("t2_br_resp", 8'(bif.BR), 8'b0000);
        bif.req_wr = '0; bif.snoop_hit = '0;
        tick(2);

        // fairness from a fresh reset (ptr back to 0)
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bif.req_rd = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'(1) << i;
            tick();
            chk($sformatf("t3_grant_%0d", i), 8'(bif.grant), e);
            tick(2);
            chk($sformatf("t3_done_%0d", i), 8'(bif.done), e);
            tick();
            chk($sformatf("t3_idle_%0d", i), 8'(bif.grant), 8'h0);
        end
        tick();
        chk("t3_grant_wrap", 8'(bif.grant), 8'b0001);
        bif.req_rd = '0;
        tick(2);
        chk("t3_drop_done", 8'(bif.done), 8'b0001);
        tick();
        chk("t3_drop_idle", 8'(bif.grant), 8'h0);
        tick();

        // only the winner hits; a hit during BCAST must not count
        bif.req_rd = 4'b0001;
        tick();
        bif.snoop_hit = 4'b0010;
        tick();
        bif.snoop_hit = 4'b0001;
        tick();
        chk("t4_done", 8'(bif.done), 8'b0001);
        chk("t4_s",    8'(bif.S),    8'b0000);
        bif.req_rd = '0; bif.snoop_hit = '0;
        tick(2);

        // held request is masked for one IDLE cycle after its RESP
        bif.req_rd = 4'b0100;
        tick();
        chk("t5_grant", 8'(bif.grant), 8'b0100);
        tick(2);
        chk("t5_done", 8'(bif.done), 8'b0100);
        tick();
        chk("t5_idle", 8'(bif.grant), 8'h0);
        tick();
        chk("t5_mask", 8'(bif.grant), 8'h0);
        tick();
        chk("t5_regrant", 8'(bif.grant), 8'b0100);
        bif.req_rd = '0;
        tick(2);
        chk("t5_done2", 8'(bif.done), 8'b0100);
        tick(2);

        // reset asserted during SNOOP
        bif.req_rd = 4'b0010;
        tick(2);
        reset = 1'b0;
        #1;
        chk("t6_grant_async", 8'(bif.grant), 8'h0);
        chk("t6_busy_async",  8'(bif.busy),  8'h0);
        chk("t6_done_async",  8'(bif.done),  8'h0);
        bif.req_rd = 4'b1000;
        tick();
        chk("t6_done_rst1", 8'(bif.done), 8'h0);
        tick();
        chk("t6_done_rst2", 8'(bif.done), 8'h0);
        reset = 1'b1;
        tick();
        chk("t6_grant_rel", 8'(bif.grant), 8'b1000);
        chk("t6_br_rel",    8'(bif.BR),    8'b0111);
        bif.req_rd = '0;
        tick(4);

        // SNOOP_LAT=3, hit only in the last SNOOP cycle
        bif3.req_rd = 4'b0001;
        tick();
        chk("t7_grant", 8'(bif3.grant), 8'b0001);
        tick(3);
        bif3.snoop_hit = 4'b0010;
        chk("t7_done_early", 8'(bif3.done), 8'h0);
        tick();
        bif3.snoop_hit = '0;
        bif3.req_rd = '0;
        chk("t7_done", 8'(bif3.done), 8'b0001);
        chk("t7_s",    8'(bif3.S),    8'b0001);
        tick();
        chk("t7_done_after", 8'(bif3.done), 8'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mesi_bus_arbiter.md
MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 Parameter N, default 4: number of cache controllers sharing the snoop bus (range 2..8).
REQ-002 Parameter SNOOP_LAT, default 1: cycles allotted for snoop responses (range 1..4).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserting it (low) forces reset values immediately, independent of clk.
REQ-005 req_rd  in  N  per-cache bus-read request (read miss); level, held until done.
REQ-006 req_wr  in  N  per-cache bus-write / read-exclusive request (write miss or upgrade); level, held until done.
REQ-007 snoop_hit  in  N  per-cache snoop response: 1 = line valid in that cache.
REQ-008 grant  out  N  one-hot ownership of the bus by the current winner.
REQ-009 BR  out  N  bus-read snoop strobe to each non-winning cache.
REQ-010 BW  out  N  bus-write snoop strobe to each non-winning cache.
REQ-011 S  out  N  shared indication to the winner, valid while done is high.
REQ-012 done  out  N  one-cycle completion strobe to the winner.
REQ-013 busy  out  1  high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, BCAST, SNOOP, RESP; all outputs are registered.
REQ-015 IDLE: a cache is eligible if req_rd[i] or req_wr[i] is high; with at least one eligible cache, the FSM SHALL latch the winner and the operation type, then go to BCAST; otherwise it stays in IDLE.
REQ-016 Winner selection SHALL be round-robin: search starts at index ptr and wraps modulo N; ptr is 0 after reset.
REQ-017 If req_rd[i] and req_wr[i] are both high, the operation type SHALL be write.
REQ-018 BCAST SHALL last exactly 1 cycle. During BCAST, BR[j] (read) or BW[j] (write) is high for every j != winner, and both are low for the winner.
REQ-019 grant[winner] SHALL be high from BCAST through RESP inclusive and low in IDLE.
REQ-020 SNOOP SHALL last exactly SNOOP_LAT cycles. snoop_hit[j], j != winner, is ORed into a sticky hit flag on each SNOOP cycle. The winner's own snoop_hit and all hits outside SNOOP are ignored.
REQ-021 RESP SHALL last 1 cycle, with done[winner]=1. For a read, S[winner] = hit flag; for a write, S[winner] = 0. All other done/S bits are 0.
REQ-022 On leaving RESP: ptr becomes (winner+1) mod N, the hit flag clears, and the FSM goes to IDLE.
REQ-023 Latency: request sampled at edge k gives BCAST in cycle k+1 and done in cycle k+2+SNOOP_LAT; back-to-back transactions start every SNOOP_LAT+3 cycles.
REQ-024 In the first IDLE cycle after RESP, the last winner's requests SHALL be masked, so a late-dropped request is not re-granted.
REQ-025 A request that drops during BCAST, SNOOP or RESP SHALL NOT abort the transaction; it completes with its latched type.
REQ-026 Requests arriving while busy SHALL NOT be lost; they are held by the requesters and arbitrated in the next IDLE.
REQ-027 grant SHALL always be one-hot or zero; BR and BW SHALL never be high on the same bit, or in any state other than BCAST.

Reset
REQ-028 While reset is low: state = IDLE, ptr = 0, hit flag = 0, and grant, BR, BW, S, done, busy all 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no done pulse; after release the FSM re-arbitrates from ptr = 0 on the first edge.

Verification
REQ-030 N=4, SNOOP_LAT=1. Single read: req_rd=0001 at edge 0, snoop_hit=0100 during SNOOP. Required: grant=0001 in cycles 1-3; BR=1110 in cycle 1 only; done=0001 and S=0001 in cycle 3.
REQ-031 Write with hits: req_wr=0010, snoop_hit=1101. Required: BW=1101 in BCAST, BR=0000 throughout, S=0000 and done=0010 in RESP.
REQ-032 Fairness: req_rd=1111 held continuously. Required: grant order 0,1,2,3,0 with one transaction every 4 cycles and no index skipped.
REQ-033 Read with only the winner hitting: req_rd=0001, snoop_hit=0001. Required: S=0000 in RESP, because the winner's own hit is ignored.
REQ-034 Reset mid-op: drive reset low during SNOOP. Required: all outputs 0 immediately and no done pulse. After release with req_rd=1000 held, grant=1000 appears at cycle 1.
REQ-035 SNOOP_LAT=3 late hit: snoop_hit pulses only in the third SNOOP cycle of a read. Required: S=1 at done, which occurs 5 cycles after the sampling edge.
